sub_serial: RTL and testbench

Multi-cycle subtractor computing D = num1 - num2 - borrowin, W bits per clock, over N/W cycles. It is the inverse-operation companion to the team's combinational N-bit carry adder. Area-lean alternative for datapaths where subtraction latency is tolerable. Valid/ready handshake on both input and result sides.

---
 rtl/sub_pkg.sv | 24 ++
 rtl/sub_digit.sv | 25 ++
 rtl/sub_serial.sv | 132 +++++++++++++
 tb/tb_sub_serial.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sub_pkg.sv
// rtl/sub_pkg.sv - shared types and elaboration helpers for the serial subtractor
package sub_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  // Smallest r with 2**r >= v; constant-bounded loop so it elaborates anywhere.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  function automatic int calc_steps(input int n, input int w);
    return n / w;
  endfunction

endpackage

// File: rtl/sub_digit.sv
// rtl/sub_digit.sv - combinational W-bit subtract-with-borrow slice
module sub_digit #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         bin,
  output logic [W-1:0] d,
  output logic         bout
);

  logic carry;

  // Adder ripple on a + ~b + ~bin: a carry out of a bit means no borrow.
  always_comb begin
    d     = '0;
    carry = ~bin;
    for (int i = 0; i < W; i++) begin
      d[i]  = a[i] ^ ~b[i] ^ carry;
      carry = (a[i] & ~b[i]) | (carry & (a[i] ^ ~b[i]));
    end
    bout = ~carry;
  end

endmodule

// File: rtl/sub_serial.sv
// rtl/sub_serial.sv - multi-cycle subtractor, W bits per clock with valid/ready handshakes
module sub_serial
  import sub_pkg::*;
#(
  parameter int N = 32,
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] num1,
  input  logic [N-1:0] num2,
  input  logic         borrowin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] D,
  output logic         borrowout,
  output logic         overflow
);

  localparam int STEPS = calc_steps(N, W);
  localparam int CW    = clog2(STEPS + 1);

  if (W < 1 || W > N || (N % W) != 0) begin : g_bad_params
    $error("sub_serial: W must divide N and satisfy 1 <= W <= N");
  end

  state_t         state_q, state_d;
  logic [N-1:0]   a_q, b_q;
  logic           borrow_q;
  logic           msb1_q, msb2_q;
  logic [CW-1:0]  cnt_q;
  logic [W-1:0]   dig;
  logic           dig_bout;
  logic [N-1:0]   r_next;
  logic           last;

  assign last = (cnt_q == CW'(STEPS - 1));

  sub_digit #(.W(W)) u_digit (
    .a    (a_q[W-1:0]),
    .b    (b_q[W-1:0]),
    .bin  (borrow_q),
    .d    (dig),
    .bout (dig_bout)
  );

  // Partial result only needs the N-W bits already produced; the new digit enters at the top.
  if (W == N) begin : g_single
    assign r_next = dig;
  end else begin : g_multi
    logic [N-W-1:0] r_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_q <= '0;
      end else if (state_q == IDLE && in_valid) begin
        r_q <= '0;
      end else if (state_q == RUN) begin
        r_q <= r_next[N-1:W];
      end
    end

    assign r_next = {dig, r_q};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = RUN;
      end
      RUN: begin
        if (last) state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q       <= '0;
      b_q       <= '0;
      borrow_q  <= 1'b0;
      msb1_q    <= 1'b0;
      msb2_q    <= 1'b0;
      cnt_q     <= '0;
      D         <= '0;
      borrowout <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q      <= num1;
            b_q      <= num2;
            borrow_q <= borrowin;
            msb1_q   <= num1[N-1];
            msb2_q   <= num2[N-1];
            cnt_q    <= '0;
          end
        end
        RUN: begin
          a_q      <= a_q >> W;
          b_q      <= b_q >> W;
          borrow_q <= dig_bout;
          cnt_q    <= cnt_q + 1'b1;
          if (last) begin
            D         <= r_next;
            borrowout <= dig_bout;
            overflow  <= (msb1_q != msb2_q) && (r_next[N-1] != msb1_q);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sub_serial.sv
// tb/tb_sub_serial.sv - directed self-checking bench for sub_serial at W=4, W=1 and W=32
module tb_sub_serial;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid  [3];
  logic        out_ready [3];
  logic        borrowin  [3];
  logic [31:0] num1      [3];
  logic [31:0] num2      [3];
  logic [31:0] d_o       [3];
  logic        in_ready  [3];
  logic        out_valid [3];
  logic        borrowout [3];
  logic        overflow  [3];

  int checks = 0;
  int errors = 0;

  logic [31:0] ca [5] = '{32'h00000005, 32'h00000000, 32'h80000000, 32'h7FFFFFFF, 32'h12345678};
  logic [31:0] cb [5] = '{32'h00000003, 32'h00000001, 32'h00000001, 32'hFFFFFFFF, 32'h12345678};
  logic        ci [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
  logic [31:0] ed [5] = '{32'h00000002, 32'hFFFFFFFF, 32'h7FFFFFFF, 32'h80000000, 32'hFFFFFFFF};
  logic        eb [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
  logic        eo [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

  always #5 clk = ~clk;

  sub_serial #(.N(32), .W(4)) u_w4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .num1(num1[0]), .num2(num2[0]), .borrowin(borrowin[0]), .out_valid(out_valid[0]),
    .out_ready(out_ready[0]), .D(d_o[0]), .borrowout(borrowout[0]), .overflow(overflow[0])
  );

  sub_serial #(.N(32), .W(1)) u_w1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .num1(num1[1]), .num2(num2[1]), .borrowin(borrowin[1]), .out_valid(out_valid[1]),
    .out_ready(out_ready[1]), .D(d_o[1]), .borrowout(borrowout[1]), .overflow(overflow[1])
  );

  sub_serial #(.N(32), .W(32)) u_w32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .num1(num1[2]), .num2(num2[2]), .borrowin(borrowin[2]), .out_valid(out_valid[2]),
    .out_ready(out_ready[2]), .D(d_o[2]), .borrowout(borrowout[2]), .overflow(overflow[2])
  );

  function automatic int steps_of(input int u);
    return (u == 0) ? 8 : (u == 1) ? 32 : 1;
  endfunction

  task automatic accept(input int u, input logic [31:0] a, input logic [31:0] b, input logic bi);
    int n = 0;
    @(negedge clk);
    while (in_ready[u] !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    num1[u]     = a;
    num2[u]     = b;
    borrowin[u] = bi;
    in_valid[u] = 1'b1;
    @(posedge clk);
    #1;
    in_valid[u] = 1'b0;
  endtask

  task automatic wait_valid(input int u, output int lat);
    lat = 0;
    while (out_valid[u] !== 1'b1 && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic handshake(input int u);
    @(negedge clk);
    out_ready[u] = 1'b1;
    @(posedge clk);
    #1;
    out_ready[u] = 1'b0;
  endtask

  task automatic test_reset;
    #1 rst_n = 1'b0;
    #11;
    for (int u = 0; u < 3; u++) begin
      checks++;
      if (in_ready[u] !== 1'b1 || out_valid[u] !== 1'b0) begin
        errors++;
        $display("FAIL reset_hs u%0d: in_ready=%b out_valid=%b want 1 0", u, in_ready[u], out_valid[u]);
      end
      checks++;
      if (d_o[u] !== 32'h0 || borrowout[u] !== 1'b0 || overflow[u] !== 1'b0) begin
        errors++;
        $display("FAIL reset_out u%0d: D=%h bo=%b ov=%b want 0 0 0", u, d_o[u], borrowout[u], overflow[u]);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_arith;
    int lat;
    for (int u = 0; u < 3; u++) begin
      for (int c = 0; c < 5; c++) begin
        accept(u, ca[c], cb[c], ci[c]);
        wait_valid(u, lat);
        checks++;
        if (lat != steps_of(u)) begin
          errors++;
          $display("FAIL arith_lat u%0d c%0d: got %0d want %0d", u, c, lat, steps_of(u));
        end
        checks++;
        if (d_o[u] !== ed[c]) begin
          errors++;
          $display("FAIL arith_D u%0d c%0d: got %h want %h", u, c, d_o[u], ed[c]);
        end
        checks++;
        if (borrowout[u] !== eb[c] || overflow[u] !== eo[c]) begin
          errors++;
          $display("FAIL arith_flags u%0d c%0d: bo=%b ov=%b want %b %b", u, c, borrowout[u], overflow[u], eb[c], eo[c]);
        end
        handshake(u);
        checks++;
        if (out_valid[u] !== 1'b0 || in_ready[u] !== 1'b1) begin
          errors++;
          $display("FAIL arith_release u%0d c%0d: out_valid=%b in_ready=%b want 0 1", u, c, out_valid[u], in_ready[u]);
        end
      end
    end
  endtask

  task automatic test_backpressure;
    int lat;
    accept(0, 32'h5, 32'h3, 1'b0);
    wait_valid(0, lat);
    checks++;
    if (lat != 8) begin
      errors++;
      $display("FAIL bp_lat: got %0d want 8", lat);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid[0] = 1'b1;
      num1[0]     = 32'h0000AAAA;
      num2[0]     = 32'h00000001;
      borrowin[0] = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if (out_valid[0] !== 1'b1 || in_ready[0] !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold_hs cyc%0d: out_valid=%b in_ready=%b want 1 0", i, out_valid[0], in_ready[0]);
      end
      checks++;
      if (d_o[0] !== 32'h2 || borrowout[0] !== 1'b0 || overflow[0] !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold_out cyc%0d: D=%h bo=%b ov=%b want 00000002 0 0", i, d_o[0], borrowout[0], overflow[0]);
      end
    end
    @(negedge clk);
    out_ready[0] = 1'b1;
    @(posedge clk);
    #1;
    out_ready[0] = 1'b0;
    checks++;
    if (out_valid[0] !== 1'b0 || in_ready[0] !== 1'b1) begin
      errors++;
      $display("FAIL bp_release: out_valid=%b in_ready=%b want 0 1", out_valid[0], in_ready[0]);
    end
    @(negedge clk);
    num1[0]     = 32'h00000100;
    num2[0]     = 32'h00000001;
    borrowin[0] = 1'b0;
    @(posedge clk);
    #1;
    in_valid[0] = 1'b0;
    checks++;
    if (in_ready[0] !== 1'b0) begin
      errors++;
      $display("FAIL bp_accept: in_ready=%b want 0", in_ready[0]);
    end
    wait_valid(0, lat);
    checks++;
    if (lat != 8 || d_o[0] !== 32'h000000FF || borrowout[0] !== 1'b0 || overflow[0] !== 1'b0) begin
      errors++;
      $display("FAIL bp_next: lat=%0d D=%h bo=%b ov=%b want 8 000000FF 0 0", lat, d_o[0], borrowout[0], overflow[0]);
    end
    handshake(0);
  endtask

  task automatic test_reset_midrun;
    int lat;
    accept(0, 32'h0, 32'h1, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (in_ready[0] !== 1'b1 || out_valid[0] !== 1'b0) begin
      errors++;
      $display("FAIL midrst_hs: in_ready=%b out_valid=%b want 1 0", in_ready[0], out_valid[0]);
    end
    checks++;
    if (d_o[0] !== 32'h0 || borrowout[0] !== 1'b0 || overflow[0] !== 1'b0) begin
      errors++;
      $display("FAIL midrst_out: D=%h bo=%b ov=%b want 0 0 0", d_o[0], borrowout[0], overflow[0]);
    end
    checks++;
    if (d_o[1] !== 32'h0 || borrowout[1] !== 1'b0) begin
      errors++;
      $display("FAIL midrst_w1: D=%h bo=%b want 0 0", d_o[1], borrowout[1]);
    end
    @(negedge clk);
    rst_n = 1'b1;
    accept(0, 32'h00000010, 32'h00000001, 1'b0);
    wait_valid(0, lat);
    checks++;
    if (lat != 8) begin
      errors++;
      $display("FAIL midrst_lat: got %0d want 8", lat);
    end
    checks++;
    if (d_o[0] !== 32'h0000000F || borrowout[0] !== 1'b0 || overflow[0] !== 1'b0) begin
      errors++;
      $display("FAIL midrst_after: D=%h bo=%b ov=%b want 0000000F 0 0", d_o[0], borrowout[0], overflow[0]);
    end
    handshake(0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int u = 0; u < 3; u++) begin
      in_valid[u]  = 1'b0;
      out_ready[u] = 1'b0;
      borrowin[u]  = 1'b0;
      num1[u]      = '0;
      num2[u]      = '0;
    end
    test_reset;
    test_arith;
    test_backpressure;
    test_reset_midrun;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
